// File: rtl/double_port_mem_ext.sv
// Simple dual-port RAM (one write port, one read port) with byte enables.
// After reset it clears itself, then serves reads with 1 + OUT_REG cycles of latency.
module double_port_mem_ext #(
    parameter int DATAW    = 32,
    parameter int SIZE     = 64,
    parameter int OUT_REG  = 0,
    parameter int WR_FIRST = 1,
    parameter int ADDRW    = $clog2(SIZE),
    parameter int BEW      = DATAW / 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             init_busy_o,
    input  logic             wr_en_i,
    input  logic [ADDRW-1:0] wr_addr_i,
    input  logic [BEW-1:0]   wr_be_i,
    input  logic [DATAW-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [ADDRW-1:0] rd_addr_i,
    output logic             rd_valid_o,
    output logic [DATAW-1:0] rd_data_o
);

    typedef enum logic {INIT, READY} state_t;

    localparam logic [ADDRW:0]   SIZE_X = (ADDRW + 1)'(SIZE);
    localparam logic [ADDRW-1:0] LAST   = ADDRW'(SIZE - 1);

    state_t           state_q, state_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;
    logic             sweep_we;
    logic             ready;
    logic             wr_ok, rd_ok;
    logic             wr_in_range, rd_in_range;
    logic [DATAW-1:0] rd_word, merged, rd_next;
    logic             v1_q;
    logic [DATAW-1:0] d1_q;

    logic [DATAW-1:0] mem [SIZE];

    // init_busy_o is the FSM state itself: high in INIT, low in READY.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sweep_we    = 1'b0;
        init_busy_o = 1'b0;
        case (state_q)
            INIT: begin
                init_busy_o = 1'b1;
                sweep_we    = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY: ;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake: rd_en_i is taken on every READY edge with no backpressure; rd_valid_o
    // is a one-cycle pulse 1 + OUT_REG cycles later, and rd_data_o holds between pulses.
    assign ready       = (state_q == READY) && !rst_i;
    assign wr_in_range = ({1'b0, wr_addr_i} < SIZE_X);
    assign rd_in_range = ({1'b0, rd_addr_i} < SIZE_X);
    assign wr_ok       = ready && wr_en_i && wr_in_range;
    assign rd_ok       = ready && rd_en_i;

    always_comb begin
        rd_word = '0;
        if (rd_in_range) rd_word = mem[rd_addr_i];
        merged = rd_word;
        for (int b = 0; b < BEW; b++) begin
            if (wr_be_i[b]) merged[8*b +: 8] = wr_data_i[8*b +: 8];
        end
        rd_next = rd_word;
        if ((WR_FIRST != 0) && wr_ok && (wr_addr_i == rd_addr_i)) rd_next = merged;
    end

    // Sweep writes only in INIT and user writes only in READY, so they never collide.
    always_ff @(posedge clk_i) begin
        if (!rst_i && sweep_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_ok) begin
            for (int b = 0; b < BEW; b++) begin
                if (wr_be_i[b]) mem[wr_addr_i][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q <= 1'b0;
            d1_q <= '0;
        end else begin
            v1_q <= rd_ok;
            if (rd_ok) d1_q <= rd_next;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             v2_q;
            logic [DATAW-1:0] d2_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    v2_q <= 1'b0;
                    d2_q <= '0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q) d2_q <= d1_q;
                end
            end
            assign rd_valid_o = v2_q;
            assign rd_data_o  = d2_q;
        end else begin : g_no_out_reg
            assign rd_valid_o = v1_q;
            assign rd_data_o  = d1_q;
        end
    endgenerate

endmodule
